// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO DIP-switch conditioning path.
package gpio_pkg;

    localparam int GPIO_DIP_WIDTH    = 32;
    localparam int GPIO_SAMPLE_DIV   = 131072;  // board driver's 17-bit scan period
    localparam int GPIO_STABLE_COUNT = 4;

endpackage

// File: rtl/gpio_sample_tick.sv
// Free-running divider that emits a one-cycle sample tick every DIV clocks.
module gpio_sample_tick #(
    parameter int DIV = 131072
) (
    input  logic clock_50,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] tick_cnt;

    assign tick = (tick_cnt == LAST);

    always_ff @(posedge clock_50) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

endmodule

// File: rtl/gpio_switch_debounce.sv
// Debounces the DIP-switch vector and accumulates per-bit rise/fall events
// for a consumer that drains them over a valid/ack handshake.
module gpio_switch_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH        = GPIO_DIP_WIDTH,
    parameter int SAMPLE_DIV   = GPIO_SAMPLE_DIV,
    parameter int STABLE_COUNT = GPIO_STABLE_COUNT
) (
    input  logic             clock_50,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dip_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             change_valid,
    input  logic             change_ack
);

    localparam int              CNTW     = $clog2(STABLE_COUNT + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(STABLE_COUNT - 1);

    logic                       tick;
    logic [WIDTH-1:0]           sync_meta, sync;
    logic [WIDTH-1:0][CNTW-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]           accept, new_rise, new_fall;
    logic [WIDTH-1:0]           clr, rise_nxt, fall_nxt;

    gpio_sample_tick #(.DIV(SAMPLE_DIV)) u_tick (
        .clock_50 (clock_50),
        .rst_n    (rst_n),
        .tick     (tick)
    );

    // A bit is accepted on the tick where it has already differed for
    // STABLE_COUNT-1 ticks; agreeing with the stable value restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic differ, hit;
        assign differ     = sync[i] ^ sw_stable[i];
        assign hit        = differ && (cnt[i] == LAST_CNT);
        assign accept[i]  = tick && hit;
        assign cnt_nxt[i] = !tick             ? cnt[i] :
                            (hit || !differ)  ? '0     :
                                                cnt[i] + 1'b1;
    end

    assign new_rise = accept & sync;
    assign new_fall = accept & ~sync;

    // Ack clears only what was visible before this edge; same-edge events survive.
    assign clr      = {WIDTH{change_ack & change_valid}};
    assign rise_nxt = (sw_rise & ~clr) | new_rise;
    assign fall_nxt = (sw_fall & ~clr) | new_fall;

    always_ff @(posedge clock_50) begin
        if (!rst_n) begin
            sync_meta    <= '0;
            sync         <= '0;
            cnt          <= '0;
            sw_stable    <= '0;
            sw_rise      <= '0;
            sw_fall      <= '0;
            change_valid <= 1'b0;
        end else begin
            sync_meta    <= dip_raw;
            sync         <= sync_meta;
            cnt          <= cnt_nxt;
            sw_stable    <= sw_stable ^ accept;
            sw_rise      <= rise_nxt;
            sw_fall      <= fall_nxt;
            change_valid <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Directed bench for gpio_switch_debounce with SAMPLE_DIV=8, STABLE_COUNT=3.
module tb_gpio_switch_debounce;

    localparam int W = 32;

    logic          clock_50 = 1'b0;
    logic          rst_n    = 1'b0;
    logic [W-1:0]  dip_raw  = '0;
    logic          change_ack = 1'b0;
    logic [W-1:0]  sw_stable, sw_rise, sw_fall;
    logic          change_valid;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;   // edges since reset release; ticks land on multiples of 8

    gpio_switch_debounce #(
        .WIDTH        (W),
        .SAMPLE_DIV   (8),
        .STABLE_COUNT (3)
    ) dut (
        .clock_50     (clock_50),
        .rst_n        (rst_n),
        .dip_raw      (dip_raw),
        .sw_stable    (sw_stable),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .change_valid (change_valid),
        .change_ack   (change_ack)
    );

    always #5 clock_50 = ~clock_50;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_cyc(input int target);
        step(target - cyc);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                           input logic [W-1:0] fa, input logic va);
        chk({tag, ".stable"}, sw_stable, st);
        chk({tag, ".rise"},   sw_rise,   ri);
        chk({tag, ".fall"},   sw_fall,   fa);
        chk({tag, ".valid"},  {31'b0, change_valid}, {31'b0, va});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        step(5);
        chk_all(tag, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // 1. reset with all switches on -> rise events after 3 ticks
        dip_raw = 32'hFFFF_FFFF;
        do_reset("rst_hold");
        goto_cyc(23);
        chk_all("rst_pre", '0, '0, '0, 1'b0);
        goto_cyc(24);
        chk_all("rst_accept", 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 1'b1);

        // 2. bounce rejection on bit 5
        dip_raw = '0;
        do_reset("rst2");
        dip_raw = 32'h20; goto_cyc(8);
        dip_raw = 32'h00; goto_cyc(16);
        dip_raw = 32'h20; goto_cyc(24);
        dip_raw = 32'h00; goto_cyc(32);
        chk_all("bounce", '0, '0, '0, 1'b0);
        dip_raw = 32'h20;
        goto_cyc(55);
        chk_all("hold_pre", '0, '0, '0, 1'b0);
        goto_cyc(56);
        chk_all("hold_accept", 32'h20, 32'h20, '0, 1'b1);

        // 4. ack on the same edge bit 7 is accepted
        dip_raw = 32'hA0;
        goto_cyc(79);
        chk_all("collide_pre", 32'h20, 32'h20, '0, 1'b1);
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        chk_all("collide", 32'hA0, 32'h80, '0, 1'b1);

        // 3. handshake clears, then ack with nothing pending is ignored
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        chk_all("ack_clear", 32'hA0, '0, '0, 1'b0);
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        chk_all("ack_idle", 32'hA0, '0, '0, 1'b0);

        // 5. bit 0 rises then falls with no ack in between
        dip_raw = 32'hA1;
        goto_cyc(104);
        chk_all("acc_rise", 32'hA1, 32'h01, '0, 1'b1);
        dip_raw = 32'hA0;
        goto_cyc(127);
        chk("acc_fall_pre", sw_fall, '0);
        goto_cyc(128);
        chk_all("acc_both", 32'hA0, 32'h01, 32'h01, 1'b1);

        // 6. reset after 2 of 3 qualifying ticks on bit 1
        dip_raw = 32'hA2;
        goto_cyc(144);
        chk("mid_pre", sw_stable, 32'hA0);
        do_reset("rst_mid");
        goto_cyc(16);
        chk_all("mid_partial", '0, '0, '0, 1'b0);
        goto_cyc(23);
        chk("mid_pre_acc", sw_stable, '0);
        goto_cyc(24);
        chk_all("mid_accept", 32'hA2, 32'hA2, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
